// File: rtl/mem_wb_stage_pkg.sv
// Shared constants for the memory-access / write-back stage.
// State encodings are plain constants so older netlists and tools can match them.
package mem_wb_stage_pkg;

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_WAIT = 1'b1;

    // Timeout counter width; clamped to at least one bit for tiny TIMEOUT values.
    function automatic int cnt_w(input int timeout);
        return (timeout <= 2) ? 1 : $clog2(timeout);
    endfunction

endpackage

// File: rtl/mem_wb_stage.sv
// Memory-access / write-back stage: ALU results go straight to the RF write port,
// loads/stores run a req/ready bus handshake and stall EX until done or timed out.
module mem_wb_stage
    import mem_wb_stage_pkg::*;
#(
    parameter int DATA_W  = 16,
    parameter int ADDR_W  = 16,
    parameter int RADDR_W = 4,
    parameter int TIMEOUT = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               ex_valid,
    output logic               ex_accept,
    input  logic               ex_reg_write,
    input  logic [RADDR_W-1:0] ex_dest_addr,
    input  logic [DATA_W-1:0]  ex_alu_value,
    input  logic               ex_mem_read,
    input  logic               ex_mem_write,
    input  logic [ADDR_W-1:0]  ex_mem_addr,
    input  logic [DATA_W-1:0]  ex_store_value,
    output logic               mem_req,
    output logic               mem_we,
    output logic [ADDR_W-1:0]  mem_addr,
    output logic [DATA_W-1:0]  mem_wdata,
    input  logic [DATA_W-1:0]  mem_rdata,
    input  logic               mem_ready,
    output logic               writable,
    output logic [RADDR_W-1:0] write_addr,
    output logic [DATA_W-1:0]  write_value,
    output logic               stall_req,
    output logic               bus_err
);

    localparam int CNT_W = cnt_w(TIMEOUT);

    logic [0:0]         state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               mem_req_q, mem_req_d;
    logic               mem_we_q, mem_we_d;
    logic [ADDR_W-1:0]  mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0]  mem_wdata_q, mem_wdata_d;
    logic               writable_q, writable_d;
    logic [RADDR_W-1:0] write_addr_q, write_addr_d;
    logic [DATA_W-1:0]  write_value_q, write_value_d;
    logic               bus_err_q, bus_err_d;
    logic [RADDR_W-1:0] ld_dest_q, ld_dest_d;
    logic               ld_wr_q, ld_wr_d;

    logic is_mem;
    logic dest_nz;

    assign is_mem  = ex_mem_read | ex_mem_write;
    assign dest_nz = (ex_dest_addr != '0);

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        mem_req_d     = mem_req_q;
        mem_we_d      = mem_we_q;
        mem_addr_d    = mem_addr_q;
        mem_wdata_d   = mem_wdata_q;
        writable_d    = 1'b0;
        write_addr_d  = write_addr_q;
        write_value_d = write_value_q;
        bus_err_d     = 1'b0;
        ld_dest_d     = ld_dest_q;
        ld_wr_d       = ld_wr_q;

        case (state_q)
            ST_IDLE: begin
                if (ex_valid) begin
                    if (is_mem) begin
                        // Read+write together is illegal upstream; resolve it as a load.
                        mem_req_d   = 1'b1;
                        mem_we_d    = ex_mem_write & ~ex_mem_read;
                        mem_addr_d  = ex_mem_addr;
                        mem_wdata_d = ex_store_value;
                        ld_dest_d   = ex_dest_addr;
                        ld_wr_d     = ex_mem_read & ex_reg_write & dest_nz;
                        cnt_d       = '0;
                        state_d     = ST_WAIT;
                    end else begin
                        writable_d    = ex_reg_write & dest_nz;
                        write_addr_d  = ex_dest_addr;
                        write_value_d = ex_alu_value;
                    end
                end
            end
            ST_WAIT: begin
                cnt_d = cnt_q + 1'b1;
                // Completion takes priority over a timeout landing on the same edge.
                if (mem_ready) begin
                    mem_req_d = 1'b0;
                    state_d   = ST_IDLE;
                    if (ld_wr_q) begin
                        writable_d    = 1'b1;
                        write_addr_d  = ld_dest_q;
                        write_value_d = mem_rdata;
                    end
                end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
                    mem_req_d = 1'b0;
                    bus_err_d = 1'b1;
                    state_d   = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= ST_IDLE;
            cnt_q         <= '0;
            mem_req_q     <= 1'b0;
            mem_we_q      <= 1'b0;
            mem_addr_q    <= '0;
            mem_wdata_q   <= '0;
            writable_q    <= 1'b0;
            write_addr_q  <= '0;
            write_value_q <= '0;
            bus_err_q     <= 1'b0;
            ld_dest_q     <= '0;
            ld_wr_q       <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            mem_req_q     <= mem_req_d;
            mem_we_q      <= mem_we_d;
            mem_addr_q    <= mem_addr_d;
            mem_wdata_q   <= mem_wdata_d;
            writable_q    <= writable_d;
            write_addr_q  <= write_addr_d;
            write_value_q <= write_value_d;
            bus_err_q     <= bus_err_d;
            ld_dest_q     <= ld_dest_d;
            ld_wr_q       <= ld_wr_d;
        end
    end

    assign ex_accept   = (state_q == ST_IDLE);
    assign stall_req   = ~ex_accept;
    assign mem_req     = mem_req_q;
    assign mem_we      = mem_we_q;
    assign mem_addr    = mem_addr_q;
    assign mem_wdata   = mem_wdata_q;
    assign writable    = writable_q;
    assign write_addr  = write_addr_q;
    assign write_value = write_value_q;
    assign bus_err     = bus_err_q;

endmodule

// File: tb/tb_mem_wb_stage.sv
// Randomized self-checking bench for mem_wb_stage: per-instruction expectations
// derived from the stage's rules, plus a register-file scoreboard.
module tb_mem_wb_stage;

    localparam int DW = 16;
    localparam int AW = 16;
    localparam int RW = 4;
    localparam int TO = 16;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          ex_valid = 1'b0;
    logic          ex_accept;
    logic          ex_reg_write = 1'b0;
    logic [RW-1:0] ex_dest_addr = '0;
    logic [DW-1:0] ex_alu_value = '0;
    logic          ex_mem_read = 1'b0;
    logic          ex_mem_write = 1'b0;
    logic [AW-1:0] ex_mem_addr = '0;
    logic [DW-1:0] ex_store_value = '0;
    logic          mem_req;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata = '0;
    logic          mem_ready = 1'b0;
    logic          writable;
    logic [RW-1:0] write_addr;
    logic [DW-1:0] write_value;
    logic          stall_req;
    logic          bus_err;

    int n_chk  = 0;
    int n_fail = 0;

    logic [DW-1:0] m_rf [16];
    logic [DW-1:0] d_rf [16];

    mem_wb_stage #(.DATA_W(DW), .ADDR_W(AW), .RADDR_W(RW), .TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst),
        .ex_valid(ex_valid), .ex_accept(ex_accept),
        .ex_reg_write(ex_reg_write), .ex_dest_addr(ex_dest_addr),
        .ex_alu_value(ex_alu_value), .ex_mem_read(ex_mem_read),
        .ex_mem_write(ex_mem_write), .ex_mem_addr(ex_mem_addr),
        .ex_store_value(ex_store_value),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
        .writable(writable), .write_addr(write_addr), .write_value(write_value),
        .stall_req(stall_req), .bus_err(bus_err)
    );

    always #5 clk = ~clk;

    // Shadow register file fed only from the DUT write port.
    always @(negedge clk) begin
        if (rst && writable) d_rf[write_addr] = write_value;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic alu_op(input logic [RW-1:0] d, input logic [DW-1:0] v, input logic rw);
        logic exp_w;
        ex_valid = 1'b1; ex_mem_read = 1'b0; ex_mem_write = 1'b0;
        ex_reg_write = rw; ex_dest_addr = d; ex_alu_value = v;
        ex_mem_addr = AW'($urandom); ex_store_value = DW'($urandom);
        mem_ready = 1'($urandom); mem_rdata = DW'($urandom);
        chk("alu_acc", ex_accept, 1);
        tick();
        exp_w = rw && (d != 0);
        chk("alu_wr", writable, exp_w);
        if (exp_w) begin
            chk("alu_wa", write_addr, d);
            chk("alu_wv", write_value, v);
            m_rf[d] = v;
        end
        chk("alu_req", mem_req, 0);
        chk("alu_err", bus_err, 0);
        chk("alu_acc2", ex_accept, 1);
    endtask

    task automatic idle_op();
        ex_valid = 1'b0; ex_reg_write = 1'b1; ex_dest_addr = RW'($urandom_range(1, 15));
        ex_mem_read = 1'($urandom); ex_mem_write = 1'($urandom);
        mem_ready = 1'($urandom); mem_rdata = DW'($urandom);
        tick();
        chk("idle_wr", writable, 0);
        chk("idle_req", mem_req, 0);
        chk("idle_acc", ex_accept, 1);
    endtask

    // dly = WAIT cycle whose edge sees mem_ready; dly > TO means the bus never answers.
    task automatic mem_op(input logic ld, input logic both, input logic [RW-1:0] d,
                          input logic rw, input logic [AW-1:0] a, input logic [DW-1:0] wd,
                          input logic [DW-1:0] rd, input int dly, input logic pend);
        logic          eff_ld;
        logic          exp_w;
        logic [RW-1:0] pd;
        logic [DW-1:0] pv;
        eff_ld = ld | both;
        pd = RW'($urandom_range(1, 15));
        pv = DW'($urandom);
        ex_valid = 1'b1; ex_mem_read = eff_ld; ex_mem_write = ~ld | both;
        ex_reg_write = rw; ex_dest_addr = d; ex_mem_addr = a; ex_store_value = wd;
        ex_alu_value = DW'($urandom); mem_ready = 1'b0;
        chk("mem_acc", ex_accept, 1);
        tick();
        chk("mem_req", mem_req, 1);
        chk("mem_we", mem_we, !eff_ld);
        chk("mem_addr", mem_addr, a);
        if (!eff_ld) chk("mem_wdata", mem_wdata, wd);
        chk("mem_wr0", writable, 0);
        chk("mem_acc0", ex_accept, 0);
        chk("mem_stall", stall_req, 1);
        if (pend) begin
            ex_valid = 1'b1; ex_mem_read = 1'b0; ex_mem_write = 1'b0;
            ex_reg_write = 1'b1; ex_dest_addr = pd; ex_alu_value = pv;
        end else begin
            ex_valid = 1'b0;
        end
        for (int k = 1; k <= TO; k++) begin
            mem_ready = (k == dly);
            mem_rdata = (k == dly) ? rd : DW'($urandom);
            tick();
            if (k == dly) begin
                exp_w = eff_ld && rw && (d != 0);
                chk("done_req", mem_req, 0);
                chk("done_err", bus_err, 0);
                chk("done_wr", writable, exp_w);
                if (exp_w) begin
                    chk("done_wa", write_addr, d);
                    chk("done_wv", write_value, rd);
                    m_rf[d] = rd;
                end
                chk("done_acc", ex_accept, 1);
                break;
            end else if (k == TO) begin
                chk("to_req", mem_req, 0);
                chk("to_err", bus_err, 1);
                chk("to_wr", writable, 0);
                chk("to_acc", ex_accept, 1);
            end else begin
                chk("hold_req", mem_req, 1);
                chk("hold_addr", mem_addr, a);
                chk("hold_we", mem_we, !eff_ld);
                chk("hold_wr", writable, 0);
                chk("hold_err", bus_err, 0);
                chk("hold_acc", ex_accept, 0);
            end
        end
        mem_ready = 1'b0;
        if (pend) begin
            chk("pend_acc", ex_accept, 1);
            tick();
            chk("pend_wr", writable, 1);
            chk("pend_wa", write_addr, pd);
            chk("pend_wv", write_value, pv);
            m_rf[pd] = pv;
        end else begin
            ex_valid = 1'b0;
            tick();
            chk("post_wr", writable, 0);
        end
        chk("post_err", bus_err, 0);
        ex_valid = 1'b0;
    endtask

    task automatic rst_mid_wait();
        ex_valid = 1'b1; ex_mem_read = 1'b1; ex_mem_write = 1'b0;
        ex_reg_write = 1'b1; ex_dest_addr = 4'd3; ex_mem_addr = 16'h4000; mem_ready = 1'b0;
        tick();
        ex_valid = 1'b0;
        tick();
        tick();
        chk("rm_req_pre", mem_req, 1);
        #2;
        rst = 1'b0;
        #1;
        chk("rm_req", mem_req, 0);
        chk("rm_wr", writable, 0);
        chk("rm_err", bus_err, 0);
        chk("rm_acc", ex_accept, 1);
        chk("rm_stall", stall_req, 0);
        @(negedge clk);
        rst = 1'b1;
        tick();
        chk("rm_acc2", ex_accept, 1);
        chk("rm_req2", mem_req, 0);
        chk("rm_wr2", writable, 0);
    endtask

    initial begin
        for (int i = 0; i < 16; i++) begin
            m_rf[i] = '0;
            d_rf[i] = '0;
        end
        #12;
        chk("rst_req", mem_req, 0);
        chk("rst_we", mem_we, 0);
        chk("rst_addr", mem_addr, 0);
        chk("rst_wdata", mem_wdata, 0);
        chk("rst_wr", writable, 0);
        chk("rst_wa", write_addr, 0);
        chk("rst_wv", write_value, 0);
        chk("rst_err", bus_err, 0);
        chk("rst_acc", ex_accept, 1);
        @(negedge clk);
        rst = 1'b1;

        alu_op(4'd1, 16'h1234, 1'b1);
        alu_op(4'd2, 16'h00FF, 1'b1);
        alu_op(4'd0, 16'hBEEF, 1'b1);
        idle_op();
        mem_op(1'b1, 1'b0, 4'd5, 1'b1, 16'h8000, 16'h0000, 16'hA5A5, 3, 1'b0);
        mem_op(1'b0, 1'b0, 4'd6, 1'b1, 16'h0010, 16'h5A5A, 16'h0000, 1, 1'b0);
        mem_op(1'b1, 1'b0, 4'd7, 1'b1, 16'h1234, 16'h0000, 16'h7777, TO + 5, 1'b0);
        mem_op(1'b1, 1'b0, 4'd9, 1'b1, 16'h2222, 16'h0000, 16'hC3C3, TO, 1'b0);
        mem_op(1'b1, 1'b0, 4'd0, 1'b1, 16'h3333, 16'h0000, 16'hDEAD, 2, 1'b1);
        mem_op(1'b0, 1'b1, 4'd4, 1'b1, 16'h4444, 16'h9999, 16'h6161, 2, 1'b1);
        mem_op(1'b0, 1'b0, 4'd8, 1'b1, 16'h5555, 16'h1357, 16'h0000, TO + 1, 1'b1);
        rst_mid_wait();

        for (int n = 0; n < 150; n++) begin
            int sel;
            sel = $urandom_range(0, 9);
            if (sel < 4) begin
                alu_op(RW'($urandom), DW'($urandom), 1'($urandom_range(0, 3) != 0));
            end else if (sel == 4) begin
                idle_op();
            end else begin
                mem_op(1'($urandom), 1'($urandom_range(0, 9) == 0), RW'($urandom),
                       1'($urandom_range(0, 3) != 0), AW'($urandom), DW'($urandom),
                       DW'($urandom), $urandom_range(1, TO + 3), 1'($urandom));
            end
        end
        idle_op();

        for (int r = 0; r < 16; r++) chk("rf", d_rf[r], m_rf[r]);

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
